// File: rtl/timer_capture_sched.sv
// timer_capture_sched: round-robin share of one pulse-width timer across N_CH channels; define TIMER_SCHED_IRQ_EN for irq.
// Result and done land SETTLE+2 cycles after the pulse falls; arms for pending or in-service channels are dropped.
module timer_capture_sched #(
   parameter int  N_CH    = 4,
   parameter int  CW      = 16,
   parameter int  TIMEOUT = 65535,
   parameter int  SETTLE  = 2,
   localparam int GW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_CH-1:0]     ch_in,
   input  logic [N_CH-1:0]     ch_arm,
   input  logic [N_CH-1:0]     ch_clear,
   output logic [N_CH-1:0]     ch_done,
   output logic [N_CH-1:0]     ch_timeout,
   output logic                ch_busy,
   output logic [GW-1:0]       grant_ch,
   output logic [N_CH*CW-1:0]  result_data,
   output logic                tmr_enable,
   output logic                tmr_final,
   input  logic [CW-1:0]       tmr_result,
   input  logic [N_CH-1:0]     irq_mask,
   output logic                irq
);
   localparam int             WDW         = 20;
   localparam logic [WDW-1:0] WD_LAST     = WDW'(TIMEOUT - 1);
   localparam logic [WDW-1:0] SETTLE_LAST = WDW'(SETTLE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_LOW,
      S_WAIT_RISE,
      S_MEASURE,
      S_SETTLE,
      S_CAPTURE
   } state_t;

   state_t               state_q, state_d;
   logic [N_CH-1:0]      pending_q, pending_d;
   logic [N_CH-1:0]      done_q, done_d;
   logic [N_CH-1:0]      tout_q, tout_d;
   logic [N_CH*CW-1:0]   result_q, result_d;
   logic [GW-1:0]        grant_q, grant_d;
   logic [GW-1:0]        rr_q, rr_d;
   logic [WDW-1:0]       cnt_q, cnt_d;
   logic                 tmr_enable_q, tmr_enable_d;
   logic                 tmr_final_q, tmr_final_d;

   logic [N_CH-1:0]      grant_oh;
   logic [N_CH-1:0]      svc_oh;
   logic [N_CH-1:0]      arm_acc;
   logic                 arb_vld;
   logic [GW-1:0]        arb_idx;
   logic                 ch_g;
   logic                 cnt_state;
   logic                 wd_hit;

   always_comb begin
      grant_oh = '0;
      for (int k = 0; k < N_CH; k++) begin
         grant_oh[k] = (grant_q == GW'(k));
      end
   end

   // First pending channel at or after the rr pointer, wrapping.
   always_comb begin
      logic [GW-1:0] sel;
      arb_vld = 1'b0;
      arb_idx = '0;
      sel     = '0;
      for (int i = 0; i < N_CH; i++) begin
         sel = GW'((int'(rr_q) + i) % N_CH);
         if (!arb_vld && pending_q[sel]) begin
            arb_vld = 1'b1;
            arb_idx = sel;
         end
      end
   end

   assign ch_g      = |(ch_in & grant_oh);
   assign cnt_state = (state_q == S_WAIT_LOW) || (state_q == S_WAIT_RISE) || (state_q == S_MEASURE);
   assign wd_hit    = cnt_state && (cnt_q == WD_LAST);
   assign svc_oh    = (state_q != S_IDLE) ? grant_oh : '0;
   assign arm_acc   = ch_arm & ~pending_q & ~svc_oh;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         pending_q    <= '0;
         done_q       <= '0;
         tout_q       <= '0;
         result_q     <= '0;
         grant_q      <= '0;
         rr_q         <= '0;
         cnt_q        <= '0;
         tmr_enable_q <= 1'b0;
         tmr_final_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         done_q       <= done_d;
         tout_q       <= tout_d;
         result_q     <= result_d;
         grant_q      <= grant_d;
         rr_q         <= rr_d;
         cnt_q        <= cnt_d;
         tmr_enable_q <= tmr_enable_d;
         tmr_final_q  <= tmr_final_d;
      end
   end

   // The watchdog takes priority over channel activity in the cycle it expires.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (arb_vld) state_d = S_WAIT_LOW;
         end
         S_WAIT_LOW: begin
            if (wd_hit)     state_d = S_IDLE;
            else if (!ch_g) state_d = S_WAIT_RISE;
         end
         S_WAIT_RISE: begin
            if (wd_hit)     state_d = S_IDLE;
            else if (ch_g)  state_d = S_MEASURE;
         end
         S_MEASURE: begin
            if (wd_hit || !ch_g) state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      pending_d = pending_q | arm_acc;
      done_d    = done_q & ~(ch_clear | arm_acc);
      tout_d    = tout_q & ~(ch_clear | arm_acc);
      result_d  = result_q;
      grant_d   = grant_q;
      rr_d      = rr_q;
      cnt_d     = cnt_q;

      if (state_q == S_IDLE && arb_vld) begin
         pending_d[arb_idx] = 1'b0;
         grant_d            = arb_idx;
         rr_d               = GW'((int'(arb_idx) + 1) % N_CH);
      end

      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (cnt_state || state_q == S_SETTLE) begin
         cnt_d = cnt_q + 1'b1;
      end

      if (wd_hit) begin
         tout_d = tout_d | grant_oh;
      end

      // Flag sets land after clears so a same-cycle clear loses.
      if (state_q == S_CAPTURE) begin
         done_d = done_d | grant_oh;
         for (int k = 0; k < N_CH; k++) begin
            if (grant_oh[k]) result_d[k*CW +: CW] = tmr_result;
         end
      end

      tmr_enable_d = (state_d == S_MEASURE);
      tmr_final_d  = (state_q == S_MEASURE) && (state_d == S_SETTLE);
   end

   assign ch_done     = done_q;
   assign ch_timeout  = tout_q;
   assign ch_busy     = (state_q != S_IDLE);
   assign grant_ch    = grant_q;
   assign result_data = result_q;
   assign tmr_enable  = tmr_enable_q;
   assign tmr_final   = tmr_final_q;

`ifdef TIMER_SCHED_IRQ_EN
   logic irq_q, irq_d;

   always_comb begin
      irq_d = |(done_q & irq_mask);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) irq_q <= 1'b0;
      else        irq_q <= irq_d;
   end

   assign irq = irq_q;
`else
   logic unused_irq_mask;
   assign unused_irq_mask = ^irq_mask;
   assign irq             = 1'b0;
`endif

endmodule
